arbitro_escrita_banco: RTL and testbench
========================================

# arbitro_escrita_banco

Write-port arbiter and hazard scoreboard for the 8×8-bit register bank of the nRisc datapath. Two writeback sources, the ALU (ULA) and the data memory (Mem), each use a valid/ready handshake to request the single bank write port (EscReg/RegEscrito/DadoEscrito). The block also tracks registers with a write still outstanding and flags read hazards to the control unit. It sits between the writeback sources and the register bank; its write outputs connect directly to the bank's write inputs.

## Interface
- NUM_REGS, 8, number of physical registers (indices 0..NUM_REGS-1)
- LARGURA_DADO, 8, data width
- LARGURA_INDICE, 4, register index width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ValidoULA / RegULA / DadoULA  in  1/4/8  ALU write request, index, data
- ProntoULA  out  1  ALU request accepted this cycle
- ValidoMem / RegMem / DadoMem  in  1/4/8  memory-load write request, index, data
- ProntoMem  out  1  memory request accepted this cycle
- Reserva / RegReserva  in  1/4  decoder marks the destination register pending
- RegLido1, RegLido2  in  4  read indices currently presented to the bank
- Pendente1, Pendente2  out  1  matching read index has an outstanding write
- EscReg / RegEscrito / DadoEscrito  out  1/4/8  to the bank write port, registered
- ErroIndice  out  1  sticky: an index ≥ NUM_REGS was presented

## Operation
- Handshake: a transfer occurs when Valido&&Pronto are both high in the same cycle. The requester holds Valido/Reg/Dado stable until Pronto. Pronto is combinational from the Valido inputs and the arbitration state. At most one Pronto is high per cycle. The bank never backpressures.
- Arbitration: a lone valid requester is granted immediately. When both are valid, the macro below decides which is granted. The loser waits with Valido held.
- Issue: on the edge ending a transfer cycle, EscReg←1, RegEscrito←Reg, DadoEscrito←Dado. With no transfer, EscReg←0 and RegEscrito/DadoEscrito hold their values.
- Out-of-range index (Reg ≥ NUM_REGS) on a transfer: the handshake completes, EscReg←0, ErroIndice←1. A Reserva with RegReserva ≥ NUM_REGS is ignored and also sets ErroIndice. ErroIndice clears only on reset.
- Scoreboard (busy[NUM_REGS-1:0]):
  - Set on an edge where Reserva=1 and the index is valid.
  - Cleared on an edge where EscReg=1 for RegEscrito. This is the same edge the bank captures the data, so Pendente stays high until the new value is readable.
  - Set and clear on the same register at the same edge: set wins.
  - Reserva on an already-busy register leaves it at 1 (no counting). The decoder must stall instead; the bench asserts on this.
- Pendente1/2 = busy[RegLido1/2], combinational. An index ≥ NUM_REGS gives 0.
- Writes to any index (including 0) are not special-cased.

## Timing
- Reset values: EscReg=0, RegEscrito=0, DadoEscrito=0, busy=0, ErroIndice=0, round-robin pointer favours ULA. ProntoULA=ProntoMem=0 while reset is high.
- Reset mid-operation: an issued-but-uncommitted write (EscReg=1 in the reset cycle) is dropped. Pending requests are not accepted until the cycle after reset deasserts.
- Latency:
  - Transfer in cycle N → EscReg=1 in cycle N+1 → bank updated at the edge ending N+1 → Pendente low and new data readable in N+2.
  - Throughput is one write per cycle.
- Back-to-back transfers to the same register: the busy bit clears at the first commit. The second write still lands in order.

## Configuration
- ARBITRO_RR_EN defined: round-robin. A 1-bit pointer records the last granted source and updates on every grant. On contention, the source not granted last wins, so each contender is served within 2 cycles.
- ARBITRO_RR_EN undefined: fixed priority, Mem > ULA. The ALU can starve while Mem is valid continuously. No pointer register is built.

## Structure
- Shared package nrisc_pkg: NUM_REGS, LARGURA_DADO, LARGURA_INDICE, and source IDs FONTE_ULA=0, FONTE_MEM=1.
- Sub-module placar_registradores: busy vector, set/clear priority, and the two combinational Pendente lookups.
- The arbitration, output registers and error flag stay in the top module.

## Test plan
- Lone ALU request, RegULA=3, DadoULA=0x5A → ProntoULA=1 that cycle; next cycle EscReg=1, RegEscrito=3, DadoEscrito=0x5A; the cycle after, EscReg=0.
- Both valid for 4 cycles (ULA→reg1, Mem→reg2, then new requests each time):
  - With ARBITRO_RR_EN: grants ULA, Mem, ULA, Mem.
  - Without it: Mem every cycle, ProntoULA=0 throughout.
- Reserva RegReserva=5; RegLido1=5 → Pendente1=1. Mem write to reg 5 → Pendente1 stays 1 through the EscReg cycle and is 0 in the following cycle.
- Same edge: Reserva on reg 6 while EscReg=1 for reg 6 → busy[6] remains 1 and Pendente=1.
- RegULA=9 transfer → ProntoULA=1, EscReg stays 0, ErroIndice=1 and stays 1 until reset.
- Reset asserted in the cycle EscReg=1 → all outputs return to their reset values next cycle, busy=0, and no further write is issued.

Source files
------------

// File: rtl/nrisc_pkg.sv
// Shared nRisc datapath constants: register bank geometry and writeback source IDs.
package nrisc_pkg;

  localparam int NUM_REGS       = 8;
  localparam int LARGURA_DADO   = 8;
  localparam int LARGURA_INDICE = 4;
  localparam int BITS_REG       = $clog2(NUM_REGS);

  typedef enum logic {
    FONTE_ULA = 1'b0,
    FONTE_MEM = 1'b1
  } fonte_t;

  function automatic logic indiceValido(input logic [LARGURA_INDICE-1:0] reg_);
    return reg_ < LARGURA_INDICE'(NUM_REGS);
  endfunction

endpackage

// File: rtl/placar_registradores.sv
// Hazard scoreboard: one busy bit per register, set by decoder reservations and
// cleared by the commit the bank captures on the same edge.
module placar_registradores
  import nrisc_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      Reserva,
  input  logic [LARGURA_INDICE-1:0] RegReserva,
  input  logic                      EscReg,
  input  logic [LARGURA_INDICE-1:0] RegEscrito,
  input  logic [LARGURA_INDICE-1:0] RegLido1,
  input  logic [LARGURA_INDICE-1:0] RegLido2,
  output logic                      Pendente1,
  output logic                      Pendente2
);

  logic [NUM_REGS-1:0] busy;

  // The set is written last so a reservation landing on the committing edge survives.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (EscReg && indiceValido(RegEscrito))
        busy[RegEscrito[BITS_REG-1:0]] <= 1'b0;
      if (Reserva && indiceValido(RegReserva))
        busy[RegReserva[BITS_REG-1:0]] <= 1'b1;
    end
  end

  always_comb begin
    Pendente1 = 1'b0;
    Pendente2 = 1'b0;
    if (indiceValido(RegLido1)) Pendente1 = busy[RegLido1[BITS_REG-1:0]];
    if (indiceValido(RegLido2)) Pendente2 = busy[RegLido2[BITS_REG-1:0]];
  end

endmodule

// File: rtl/arbitro_escrita_banco.sv
// Write-port arbiter for the nRisc register bank (ULA vs Mem) plus hazard flags.
// Define ARBITRO_RR_EN for round-robin contention; default is fixed priority Mem > ULA.
module arbitro_escrita_banco
  import nrisc_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ValidoULA,
  input  logic [LARGURA_INDICE-1:0] RegULA,
  input  logic [LARGURA_DADO-1:0]   DadoULA,
  output logic                      ProntoULA,
  input  logic                      ValidoMem,
  input  logic [LARGURA_INDICE-1:0] RegMem,
  input  logic [LARGURA_DADO-1:0]   DadoMem,
  output logic                      ProntoMem,
  input  logic                      Reserva,
  input  logic [LARGURA_INDICE-1:0] RegReserva,
  input  logic [LARGURA_INDICE-1:0] RegLido1,
  input  logic [LARGURA_INDICE-1:0] RegLido2,
  output logic                      Pendente1,
  output logic                      Pendente2,
  output logic                      EscReg,
  output logic [LARGURA_INDICE-1:0] RegEscrito,
  output logic [LARGURA_DADO-1:0]   DadoEscrito,
  output logic                      ErroIndice
);

  logic                      transfere;
  logic                      selValido;
  logic [LARGURA_INDICE-1:0] regSel;
  logic [LARGURA_DADO-1:0]   dadoSel;

`ifdef ARBITRO_RR_EN
  // ultimaFonte | meaning
  // FONTE_ULA   | ULA granted last, Mem wins next contention
  // FONTE_MEM   | Mem granted last (or reset), ULA wins next contention
  fonte_t ultimaFonte;

  always_ff @(posedge clock) begin
    if (reset)          ultimaFonte <= FONTE_MEM;
    else if (ProntoULA) ultimaFonte <= FONTE_ULA;
    else if (ProntoMem) ultimaFonte <= FONTE_MEM;
  end
`endif

  always_comb begin
    ProntoULA = 1'b0;
    ProntoMem = 1'b0;
    if (!reset) begin
      if (ValidoULA && ValidoMem) begin
`ifdef ARBITRO_RR_EN
        if (ultimaFonte == FONTE_MEM) ProntoULA = 1'b1;
        else                          ProntoMem = 1'b1;
`else
        ProntoMem = 1'b1;
`endif
      end else begin
        ProntoULA = ValidoULA;
        ProntoMem = ValidoMem;
      end
    end
  end

  assign transfere = ProntoULA || ProntoMem;
  assign regSel    = ProntoMem ? RegMem  : RegULA;
  assign dadoSel   = ProntoMem ? DadoMem : DadoULA;
  assign selValido = indiceValido(regSel);

  // Out-of-range transfers still complete the handshake but never reach the bank.
  always_ff @(posedge clock) begin
    if (reset) begin
      EscReg      <= 1'b0;
      RegEscrito  <= '0;
      DadoEscrito <= '0;
      ErroIndice  <= 1'b0;
    end else begin
      EscReg <= transfere && selValido;
      if (transfere && selValido) begin
        RegEscrito  <= regSel;
        DadoEscrito <= dadoSel;
      end
      if ((transfere && !selValido) || (Reserva && !indiceValido(RegReserva)))
        ErroIndice <= 1'b1;
    end
  end

  placar_registradores uPlacar (
    .clock      (clock),
    .reset      (reset),
    .Reserva    (Reserva),
    .RegReserva (RegReserva),
    .EscReg     (EscReg),
    .RegEscrito (RegEscrito),
    .RegLido1   (RegLido1),
    .RegLido2   (RegLido2),
    .Pendente1  (Pendente1),
    .Pendente2  (Pendente2)
  );

endmodule

// File: tb/tb_arbitro_escrita_banco.sv
// Bench for arbitro_escrita_banco: directed scenarios plus randomized traffic against a behavioural model.
module tb_arbitro_escrita_banco;

  logic       clock = 1'b0;
  logic       reset;
  logic       ValidoULA, ValidoMem, Reserva;
  logic [3:0] RegULA, RegMem, RegReserva, RegLido1, RegLido2;
  logic [7:0] DadoULA, DadoMem;
  logic       ProntoULA, ProntoMem, Pendente1, Pendente2, EscReg, ErroIndice;
  logic [3:0] RegEscrito;
  logic [7:0] DadoEscrito;

  int passed = 0;
  int total  = 0;

  // behavioural model state
  logic [7:0] mBusy;
  logic       mEsc, mErr, mLastMem;
  logic [3:0] mReg;
  logic [7:0] mDado;
  logic       expU, expM;

  arbitro_escrita_banco dut (
    .clock(clock), .reset(reset),
    .ValidoULA(ValidoULA), .RegULA(RegULA), .DadoULA(DadoULA), .ProntoULA(ProntoULA),
    .ValidoMem(ValidoMem), .RegMem(RegMem), .DadoMem(DadoMem), .ProntoMem(ProntoMem),
    .Reserva(Reserva), .RegReserva(RegReserva),
    .RegLido1(RegLido1), .RegLido2(RegLido2),
    .Pendente1(Pendente1), .Pendente2(Pendente2),
    .EscReg(EscReg), .RegEscrito(RegEscrito), .DadoEscrito(DadoEscrito),
    .ErroIndice(ErroIndice)
  );

  always #5 clock = ~clock;

  function automatic logic pend(input logic [3:0] r);
    return (r < 4'd8) ? mBusy[r[2:0]] : 1'b0;
  endfunction

  // Expected grants from the current inputs and the model's history.
  task automatic prever();
    expU = 1'b0;
    expM = 1'b0;
    if (!reset) begin
      if (ValidoULA && ValidoMem) begin
`ifdef ARBITRO_RR_EN
        if (mLastMem) expU = 1'b1; else expM = 1'b1;
`else
        expM = 1'b1;
`endif
      end else begin
        expU = ValidoULA;
        expM = ValidoMem;
      end
    end
  endtask

  // One clock edge: model next state from the current inputs, then advance both.
  task automatic avanca();
    logic [7:0] nBusy;
    logic       nEsc, nErr, nLast;
    logic [3:0] nReg, r;
    logic [7:0] nDado, d;
    prever();
    if (reset) begin
      nBusy = '0; nEsc = 0; nErr = 0; nLast = 1; nReg = '0; nDado = '0;
    end else begin
      nBusy = mBusy;
      if (mEsc) nBusy[mReg[2:0]] = 1'b0;
      if (Reserva && RegReserva < 4'd8) begin
        assert (!mBusy[RegReserva[2:0]]) else $error("decoder reserved a busy register %0d", RegReserva);
        nBusy[RegReserva[2:0]] = 1'b1;
      end
      r = expM ? RegMem : RegULA;
      d = expM ? DadoMem : DadoULA;
      nEsc = (expU || expM) && (r < 4'd8);
      nReg = nEsc ? r : mReg;
      nDado = nEsc ? d : mDado;
      nErr = mErr || ((expU || expM) && r >= 4'd8) || (Reserva && RegReserva >= 4'd8);
      nLast = expM ? 1'b1 : (expU ? 1'b0 : mLastMem);
    end
    @(posedge clock);
    #1;
    mBusy = nBusy; mEsc = nEsc; mErr = nErr; mLastMem = nLast; mReg = nReg; mDado = nDado;
  endtask

  task automatic quieto();
    ValidoULA = 0; ValidoMem = 0; Reserva = 0;
    RegULA = 0; RegMem = 0; DadoULA = 0; DadoMem = 0; RegReserva = 0;
    RegLido1 = 0; RegLido2 = 0;
  endtask

  task automatic do_reset();
    quieto();
    reset = 1;
    avanca();
    reset = 0;
  endtask

  task automatic test_reset();
    quieto();
    reset = 1;
    ValidoULA = 1; RegULA = 4'd2; DadoULA = 8'h11;
    #1;
    total++; if (ProntoULA !== 1'b0) $display("FAIL reset_pronto_ula got %b want 0", ProntoULA); else passed++;
    avanca();
    avanca();
    total++; if (EscReg !== 1'b0) $display("FAIL reset_escreg got %b want 0", EscReg); else passed++;
    total++; if (RegEscrito !== 4'd0 || DadoEscrito !== 8'd0)
      $display("FAIL reset_saidas got reg=%0d dado=%h want 0/00", RegEscrito, DadoEscrito); else passed++;
    total++; if (ErroIndice !== 1'b0) $display("FAIL reset_erro got %b want 0", ErroIndice); else passed++;
    for (int i = 0; i < 8; i++) begin
      RegLido1 = 4'(i); RegLido2 = 4'(7 - i);
      #1;
      total++; if (Pendente1 !== 1'b0 || Pendente2 !== 1'b0)
        $display("FAIL reset_pendente idx=%0d got %b%b want 00", i, Pendente1, Pendente2); else passed++;
    end
    quieto();
    reset = 0;
    avanca();
  endtask

  task automatic test_ula_sozinha();
    do_reset();
    ValidoULA = 1; RegULA = 4'd3; DadoULA = 8'h5A;
    #1;
    total++; if (ProntoULA !== 1'b1 || ProntoMem !== 1'b0)
      $display("FAIL ula_pronto got ula=%b mem=%b want 1/0", ProntoULA, ProntoMem); else passed++;
    avanca();
    ValidoULA = 0;
    total++; if (EscReg !== 1'b1 || RegEscrito !== 4'd3 || DadoEscrito !== 8'h5A)
      $display("FAIL ula_escrita got esc=%b reg=%0d dado=%h want 1/3/5a", EscReg, RegEscrito, DadoEscrito); else passed++;
    avanca();
    total++; if (EscReg !== 1'b0) $display("FAIL ula_escreg_apos got %b want 0", EscReg); else passed++;
  endtask

  task automatic test_contencao();
    logic [3:0] wantU;
    logic [7:0] du, dm;
    do_reset();
`ifdef ARBITRO_RR_EN
    wantU = 4'b0101;
`else
    wantU = 4'b0000;
`endif
    du = 8'hA0; dm = 8'hB0;
    ValidoULA = 1; RegULA = 4'd1; ValidoMem = 1; RegMem = 4'd2;
    for (int c = 0; c < 4; c++) begin
      DadoULA = du; DadoMem = dm;
      #1;
      total++; if (ProntoULA !== wantU[c] || ProntoMem !== !wantU[c])
        $display("FAIL contencao_grant c=%0d got ula=%b mem=%b want ula=%b", c, ProntoULA, ProntoMem, wantU[c]); else passed++;
      avanca();
      total++; if (EscReg !== 1'b1 || RegEscrito !== (wantU[c] ? 4'd1 : 4'd2) || DadoEscrito !== (wantU[c] ? du : dm))
        $display("FAIL contencao_escrita c=%0d got esc=%b reg=%0d dado=%h", c, EscReg, RegEscrito, DadoEscrito); else passed++;
      if (wantU[c]) du = du + 8'd1; else dm = dm + 8'd1;
    end
    quieto();
    avanca();
  endtask

  task automatic test_placar();
    do_reset();
    Reserva = 1; RegReserva = 4'd5; RegLido1 = 4'd5;
    avanca();
    Reserva = 0;
    total++; if (Pendente1 !== 1'b1) $display("FAIL placar_reserva got %b want 1", Pendente1); else passed++;
    ValidoMem = 1; RegMem = 4'd5; DadoMem = 8'h77;
    avanca();
    ValidoMem = 0;
    total++; if (EscReg !== 1'b1 || Pendente1 !== 1'b1)
      $display("FAIL placar_ciclo_esc got esc=%b pend=%b want 1/1", EscReg, Pendente1); else passed++;
    avanca();
    total++; if (Pendente1 !== 1'b0) $display("FAIL placar_limpo got %b want 0", Pendente1); else passed++;
  endtask

  task automatic test_mesma_borda();
    do_reset();
    RegLido2 = 4'd6;
    ValidoULA = 1; RegULA = 4'd6; DadoULA = 8'h66;
    avanca();
    ValidoULA = 0;
    Reserva = 1; RegReserva = 4'd6;
    total++; if (EscReg !== 1'b1 || RegEscrito !== 4'd6)
      $display("FAIL borda_esc got esc=%b reg=%0d want 1/6", EscReg, RegEscrito); else passed++;
    avanca();
    Reserva = 0;
    total++; if (Pendente2 !== 1'b1) $display("FAIL borda_set_vence got %b want 1", Pendente2); else passed++;
    avanca();
    total++; if (Pendente2 !== 1'b1) $display("FAIL borda_mantem got %b want 1", Pendente2); else passed++;
  endtask

  task automatic test_indice_invalido();
    do_reset();
    ValidoULA = 1; RegULA = 4'd9; DadoULA = 8'h99;
    #1;
    total++; if (ProntoULA !== 1'b1) $display("FAIL invalido_pronto got %b want 1", ProntoULA); else passed++;
    avanca();
    ValidoULA = 0;
    total++; if (EscReg !== 1'b0 || ErroIndice !== 1'b1)
      $display("FAIL invalido_efeito got esc=%b erro=%b want 0/1", EscReg, ErroIndice); else passed++;
    Reserva = 1; RegReserva = 4'd12; RegLido1 = 4'd12;
    avanca();
    Reserva = 0;
    for (int i = 0; i < 3; i++) avanca();
    total++; if (ErroIndice !== 1'b1 || Pendente1 !== 1'b0)
      $display("FAIL invalido_pegajoso got erro=%b pend=%b want 1/0", ErroIndice, Pendente1); else passed++;
  endtask

  task automatic test_reset_meio();
    do_reset();
    Reserva = 1; RegReserva = 4'd7; RegLido1 = 4'd7;
    avanca();
    Reserva = 0;
    ValidoULA = 1; RegULA = 4'd4; DadoULA = 8'hC3;
    avanca();
    ValidoULA = 0;
    reset = 1;
    ValidoMem = 1; RegMem = 4'd1; DadoMem = 8'h12;
    #1;
    total++; if (EscReg !== 1'b1 || ProntoMem !== 1'b0)
      $display("FAIL reset_meio_pre got esc=%b pronto=%b want 1/0", EscReg, ProntoMem); else passed++;
    avanca();
    reset = 0;
    ValidoMem = 0;
    total++; if (EscReg !== 1'b0 || RegEscrito !== 4'd0 || DadoEscrito !== 8'd0 || ErroIndice !== 1'b0 || Pendente1 !== 1'b0)
      $display("FAIL reset_meio_pos got esc=%b reg=%0d dado=%h erro=%b pend=%b want all 0",
               EscReg, RegEscrito, DadoEscrito, ErroIndice, Pendente1); else passed++;
    avanca();
    total++; if (EscReg !== 1'b0) $display("FAIL reset_meio_sem_escrita got %b want 0", EscReg); else passed++;
  endtask

  task automatic test_aleatorio();
    int erros = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic gU, gM;
      logic [3:0] r;
      if (!ValidoULA && $urandom_range(0, 2) != 0) begin
        ValidoULA = 1;
        RegULA = ($urandom_range(0, 40) == 0) ? 4'd9 : 4'($urandom_range(0, 7));
        DadoULA = 8'($urandom);
      end
      if (!ValidoMem && $urandom_range(0, 2) == 0) begin
        ValidoMem = 1;
        RegMem = 4'($urandom_range(0, 7));
        DadoMem = 8'($urandom);
      end
      r = 4'($urandom_range(0, 7));
      Reserva = ($urandom_range(0, 3) == 0) && !mBusy[r[2:0]];
      RegReserva = r;
      RegLido1 = 4'($urandom_range(0, 9));
      RegLido2 = 4'($urandom_range(0, 9));
      #1;
      prever();
      gU = expU; gM = expM;
      total++;
      if (ProntoULA !== gU || ProntoMem !== gM) begin
        erros++;
        if (erros < 10) $display("FAIL aleat_pronto c=%0d got %b%b want %b%b", c, ProntoULA, ProntoMem, gU, gM);
      end else passed++;
      avanca();
      if (gU) ValidoULA = 0;
      if (gM) ValidoMem = 0;
      Reserva = 0;
      #1;
      total++;
      if (EscReg !== mEsc || RegEscrito !== mReg || DadoEscrito !== mDado || ErroIndice !== mErr
          || Pendente1 !== pend(RegLido1) || Pendente2 !== pend(RegLido2)) begin
        erros++;
        if (erros < 10)
          $display("FAIL aleat_saidas c=%0d got esc=%b reg=%0d dado=%h erro=%b p=%b%b want %b/%0d/%h/%b/%b%b",
                   c, EscReg, RegEscrito, DadoEscrito, ErroIndice, Pendente1, Pendente2,
                   mEsc, mReg, mDado, mErr, pend(RegLido1), pend(RegLido2));
      end else passed++;
    end
  endtask

  initial begin
    mBusy = '0; mEsc = 0; mErr = 0; mLastMem = 1; mReg = '0; mDado = '0;
    expU = 0; expM = 0;
    reset = 1;
    quieto();
    @(negedge clock);
    test_reset();
    test_ula_sozinha();
    test_contencao();
    test_placar();
    test_mesma_borda();
    test_indice_invalido();
    test_reset_meio();
    test_aleatorio();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
